// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: opcodes, controller states and the
// control word the decoder hands to the sequencing FSM.
package cpu_pkg;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLdi = 4'h1;
  localparam logic [3:0] OpLda = 4'h2;
  localparam logic [3:0] OpSta = 4'h3;
  localparam logic [3:0] OpAdd = 4'h4;
  localparam logic [3:0] OpSub = 4'h5;
  localparam logic [3:0] OpAnd = 4'h6;
  localparam logic [3:0] OpJmp = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpJc  = 4'h9;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    AccImm = 2'd0,
    AccMem = 2'd1,
    AccAlu = 2'd2
  } acc_src_e;

  typedef enum logic [1:0] {
    AluAdd = 2'd0,
    AluSub = 2'd1,
    AluAnd = 2'd2
  } alu_op_e;

  typedef struct packed {
    acc_src_e acc_src;
    logic     acc_we;
    alu_op_e  alu_op;
    logic     flags_we;
    logic     mem_we;
    logic     pc_enable;
    logic     pc_load;
    logic     illegal;
  } ctrl_t;

  localparam ctrl_t CtrlNone = '{
    acc_src:   AccImm,
    acc_we:    1'b0,
    alu_op:    AluAdd,
    flags_we:  1'b0,
    mem_we:    1'b0,
    pc_enable: 1'b0,
    pc_load:   1'b0,
    illegal:   1'b0
  };

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: opcode plus Z/C flags to the EXECUTE
// control word. Undefined opcodes run as NOP and flag illegal.
module cpu_decode
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0] opcode_i,
  input  logic           zero_i,
  input  logic           carry_i,
  output ctrl_t          ctrl_o
);

  always_comb begin
    ctrl_o = CtrlNone;
    unique case (opcode_i)
      OpNop: ctrl_o.pc_enable = 1'b1;
      OpLdi: begin
        ctrl_o.acc_src   = AccImm;
        ctrl_o.acc_we    = 1'b1;
        ctrl_o.pc_enable = 1'b1;
      end
      OpLda: begin
        ctrl_o.acc_src   = AccMem;
        ctrl_o.acc_we    = 1'b1;
        ctrl_o.pc_enable = 1'b1;
      end
      OpSta: begin
        ctrl_o.mem_we    = 1'b1;
        ctrl_o.pc_enable = 1'b1;
      end
      OpAdd, OpSub, OpAnd: begin
        ctrl_o.acc_src   = AccAlu;
        ctrl_o.alu_op    = (opcode_i == OpAdd) ? AluAdd :
                           (opcode_i == OpSub) ? AluSub : AluAnd;
        ctrl_o.acc_we    = 1'b1;
        ctrl_o.flags_we  = 1'b1;
        ctrl_o.pc_enable = 1'b1;
      end
      OpJmp: ctrl_o.pc_load = 1'b1;
      OpJz: begin
        ctrl_o.pc_load   = zero_i;
        ctrl_o.pc_enable = ~zero_i;
      end
      OpJc: begin
        ctrl_o.pc_load   = carry_i;
        ctrl_o.pc_enable = ~carry_i;
      end
      OpHlt: ctrl_o = CtrlNone;
      default: begin
        ctrl_o.illegal   = 1'b1;
        ctrl_o.pc_enable = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multicycle controller: IDLE -> FETCH -> DECODE -> EXECUTE loop with HALT.
// Every output is a flop loaded from the next-state decode.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int unsigned OPW  = 4,
  parameter int unsigned ARGW = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPW+ARGW-1:0] instr,
  input  logic                zero,
  input  logic                carry,
  output logic                ir_load,
  output logic                pc_enable,
  output logic                pc_load,
  output logic [ARGW-1:0]     pc_target,
  output logic [1:0]          acc_src,
  output logic                acc_we,
  output logic [1:0]          alu_op,
  output logic                flags_we,
  output logic                mem_we,
  output logic                halted,
  output logic                illegal
);

  state_e              state_q, state_d;
  logic [OPW+ARGW-1:0] ir_q, ir_d;
  ctrl_t               ctrl_q, ctrl_d, dec_ctrl;
  logic                ir_load_q, ir_load_d;
  logic                halted_q, halted_d;

  // Flags are read while in DECODE so the control word lands in EXECUTE.
  cpu_decode #(
    .OPW(OPW)
  ) u_decode (
    .opcode_i(ir_q[OPW+ARGW-1:ARGW]),
    .zero_i  (zero),
    .carry_i (carry),
    .ctrl_o  (dec_ctrl)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle:    if (run) state_d = StFetch;
      StFetch: begin
        state_d = StDecode;
        ir_d    = instr;
      end
      StDecode:  state_d = StExecute;
      StExecute: state_d = (ir_q[OPW+ARGW-1:ARGW] == OpHlt) ? StHalt : StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StIdle;
    endcase

    ctrl_d    = (state_d == StExecute) ? dec_ctrl : CtrlNone;
    ir_load_d = (state_d == StFetch);
    halted_d  = (state_d == StHalt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      ctrl_q    <= CtrlNone;
      ir_load_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ctrl_q    <= ctrl_d;
      ir_load_q <= ir_load_d;
      halted_q  <= halted_d;
    end
  end

  assign ir_load   = ir_load_q;
  assign pc_enable = ctrl_q.pc_enable;
  assign pc_load   = ctrl_q.pc_load;
  assign pc_target = ir_q[ARGW-1:0];
  assign acc_src   = ctrl_q.acc_src;
  assign acc_we    = ctrl_q.acc_we;
  assign alu_op    = ctrl_q.alu_op;
  assign flags_we  = ctrl_q.flags_we;
  assign mem_we    = ctrl_q.mem_we;
  assign halted    = halted_q;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_cpu_control.sv
// Scoreboard bench for cpu_control: stimulus queues per-cycle expected output
// words tagged with a cycle number; a negedge monitor pops and compares.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] instr;
  logic       zero, carry;
  logic       ir_load, pc_enable, pc_load, acc_we, flags_we, mem_we, halted, illegal;
  logic [3:0] pc_target;
  logic [1:0] acc_src, alu_op;

  cpu_control #(.OPW(4), .ARGW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .instr    (instr),
    .zero     (zero),
    .carry    (carry),
    .ir_load  (ir_load),
    .pc_enable(pc_enable),
    .pc_load  (pc_load),
    .pc_target(pc_target),
    .acc_src  (acc_src),
    .acc_we   (acc_we),
    .alu_op   (alu_op),
    .flags_we (flags_we),
    .mem_we   (mem_we),
    .halted   (halted),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  // [15]ir_load [14]pc_enable [13]pc_load [12:9]pc_target [8:7]acc_src [6]acc_we
  // [5:4]alu_op [3]flags_we [2]mem_we [1]halted [0]illegal
  logic [15:0] act;
  assign act = {ir_load, pc_enable, pc_load, pc_target, acc_src, acc_we, alu_op,
                flags_we, mem_we, halted, illegal};

  typedef struct {
    int unsigned tag;
    logic [15:0] exp;
    string       name;
  } item_t;

  item_t       sb[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [3:0]  prev_tgt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      item_t it;
      it = sb.pop_front();
      if (it.tag < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: stale entry tag %0d at cyc %0d", it.name, it.tag, cyc);
      end else begin
        check(it.name, act, it.exp);
      end
    end
  end

  // Expect exp on the outputs after the next rising edge.
  task automatic step(input logic [15:0] exp, input string name);
    item_t it;
    it.tag  = cyc + 1;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] xw(input logic pe, input logic pl, input logic [1:0] src,
                                     input logic we, input logic [1:0] alu, input logic fwe,
                                     input logic mwe, input logic ill);
    return {1'b0, pe, pl, 4'h0, src, we, alu, fwe, mwe, 1'b0, ill};
  endfunction

  function automatic logic [15:0] with_tgt(input logic [15:0] w, input logic [3:0] t);
    logic [15:0] r;
    r = w;
    r[12:9] = t;
    return r;
  endfunction

  // Runs FETCH/DECODE/EXECUTE; caller guarantees the next edge enters FETCH.
  task automatic run_instr(input logic [7:0] ins, input logic z, input logic c,
                           input logic [15:0] exec, input string name);
    logic [3:0] op;
    op    = ins[3:0];
    instr = ins;
    zero  = z;
    carry = c;
    step(with_tgt(16'h8000, prev_tgt), {name, "_fetch"});
    step(with_tgt(16'h0000, op), {name, "_decode"});
    step(with_tgt(exec, op), {name, "_exec"});
    prev_tgt = op;
  endtask

  initial begin
    reset    = 1'b0;
    run      = 1'b0;
    instr    = 8'h00;
    zero     = 1'b0;
    carry    = 1'b0;
    prev_tgt = 4'h0;

    repeat (3) step(16'h0000, "rst_hold");
    reset = 1'b1;
    repeat (5) step(16'h0000, "idle_run0");

    run = 1'b1;
    run_instr(8'h13, 1'b0, 1'b0, xw(1, 0, 2'd0, 1, 2'd0, 0, 0, 0), "ldi3");
    run = 1'b0;
    run_instr(8'h42, 1'b0, 1'b0, xw(1, 0, 2'd2, 1, 2'd0, 1, 0, 0), "add2");
    run_instr(8'h35, 1'b0, 1'b0, xw(1, 0, 2'd0, 0, 2'd0, 0, 1, 0), "sta5");
    run_instr(8'h89, 1'b1, 1'b0, xw(0, 1, 2'd0, 0, 2'd0, 0, 0, 0), "jz_taken");
    run_instr(8'h89, 1'b0, 1'b1, xw(1, 0, 2'd0, 0, 2'd0, 0, 0, 0), "jz_not");
    run_instr(8'h99, 1'b0, 1'b1, xw(0, 1, 2'd0, 0, 2'd0, 0, 0, 0), "jc_taken");
    run_instr(8'h99, 1'b1, 1'b0, xw(1, 0, 2'd0, 0, 2'd0, 0, 0, 0), "jc_not");
    run_instr(8'h51, 1'b0, 1'b0, xw(1, 0, 2'd2, 1, 2'd1, 1, 0, 0), "sub1");
    run_instr(8'h6A, 1'b0, 1'b0, xw(1, 0, 2'd2, 1, 2'd2, 1, 0, 0), "andA");
    run_instr(8'h24, 1'b0, 1'b0, xw(1, 0, 2'd1, 1, 2'd0, 0, 0, 0), "lda4");
    run_instr(8'h77, 1'b0, 1'b0, xw(0, 1, 2'd0, 0, 2'd0, 0, 0, 0), "jmp7");
    run_instr(8'h00, 1'b0, 1'b0, xw(1, 0, 2'd0, 0, 2'd0, 0, 0, 0), "nop");
    run_instr(8'hB2, 1'b0, 1'b0, xw(1, 0, 2'd0, 0, 2'd0, 0, 0, 1), "illB");

    // Abort an STA while mem_we is high.
    run_instr(8'h35, 1'b0, 1'b0, xw(1, 0, 2'd0, 0, 2'd0, 0, 1, 0), "sta_abort");
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check("rst_async", act, 16'h0000);
    prev_tgt = 4'h0;
    repeat (2) step(16'h0000, "rst_mid_hold");
    reset = 1'b1;
    repeat (2) step(16'h0000, "post_rst_idle");

    run = 1'b1;
    run_instr(8'h00, 1'b0, 1'b0, xw(1, 0, 2'd0, 0, 2'd0, 0, 0, 0), "nop_after_rst");
    run_instr(8'hEE, 1'b0, 1'b0, xw(1, 0, 2'd0, 0, 2'd0, 0, 0, 1), "illE");
    run_instr(8'hF0, 1'b1, 1'b1, 16'h0000, "hlt");
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      step(16'h0002, "halted");
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
